// File: rtl/pc_attack_engine.sv
// rtl/pc_attack_engine.sv - computer-opponent turn engine: LFSR-seeded probe for an unshot cell, strike, record
module pc_attack_engine #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_turn,
    input  logic        clear_board,
    input  logic [24:0] ship_map,
    output logic        pc_move,
    output logic [2:0]  attack_row,
    output logic [2:0]  attack_col,
    output logic        attack_hit,
    output logic        no_target,
    output logic [24:0] shot_mask,
    output logic [24:0] hit_mask,
    output logic [4:0]  player_ships
);

    typedef enum logic [1:0] {IDLE, PROBE, STRIKE, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  lfsr;
    logic [4:0]  cand;
    logic [4:0]  cnt;
    logic [4:0]  start_idx;
    logic [2:0]  cand_row;
    logic [2:0]  cand_col;
    logic [24:0] live_cells;

    // Fold the 0..31 LFSR slice into the 0..24 cell range.
    assign start_idx = (lfsr[4:0] >= 5'd25) ? (lfsr[4:0] - 5'd25) : lfsr[4:0];
    assign pc_move   = (state == DONE);

    always_comb begin
        cand_row = 3'd0;
        if (cand >= 5'd20)      cand_row = 3'd4;
        else if (cand >= 5'd15) cand_row = 3'd3;
        else if (cand >= 5'd10) cand_row = 3'd2;
        else if (cand >= 5'd5)  cand_row = 3'd1;
        cand_col = 3'(cand - (5'(cand_row) * 5'd5));
    end

    assign live_cells = ship_map & ~shot_mask;

    always_comb begin
        player_ships = 5'd0;
        for (int i = 0; i < 25; i++) begin
            player_ships = player_ships + 5'(live_cells[i]);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pc_turn) state_nx = PROBE;
            PROBE: begin
                if (!shot_mask[cand])   state_nx = STRIKE;
                else if (cnt == 5'd24)  state_nx = DONE;
            end
            STRIKE:  state_nx = DONE;
            DONE:    if (!pc_turn) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear_board) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED;
            cand       <= 5'd0;
            cnt        <= 5'd0;
            shot_mask  <= 25'd0;
            hit_mask   <= 25'd0;
            attack_row <= 3'd0;
            attack_col <= 3'd0;
            attack_hit <= 1'b0;
            no_target  <= 1'b0;
        end else begin
            // Free-running: the turn's start cell depends on when the request arrives.
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (clear_board) begin
                shot_mask  <= 25'd0;
                hit_mask   <= 25'd0;
                attack_hit <= 1'b0;
                no_target  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pc_turn) begin
                            cand <= start_idx;
                            cnt  <= 5'd0;
                        end
                    end
                    PROBE: begin
                        if (shot_mask[cand]) begin
                            if (cnt == 5'd24) begin
                                no_target <= 1'b1;
                            end else begin
                                cand <= (cand == 5'd24) ? 5'd0 : cand + 5'd1;
                                cnt  <= cnt + 5'd1;
                            end
                        end
                    end
                    STRIKE: begin
                        shot_mask[cand] <= 1'b1;
                        hit_mask[cand]  <= hit_mask[cand] | ship_map[cand];
                        attack_hit      <= ship_map[cand];
                        attack_row      <= cand_row;
                        attack_col      <= cand_col;
                        no_target       <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
